// File: rtl/dfi_tdm_bridge_pkg.sv
// Shared encodings for the DFI time-division bridge: command codes, return
// framing codes and the init FSM states.
package dfi_tdm_pkg;

   typedef enum logic [1:0] {
      CMD_NOP     = 2'b00,
      CMD_READ    = 2'b01,
      CMD_WRITE   = 2'b10,
      CMD_REFRESH = 2'b11
   } cmd_e;

   localparam logic [1:0] CNTL_MOM     = 2'b00;
   localparam logic [1:0] CNTL_SOM     = 2'b01;
   localparam logic [1:0] CNTL_EOM     = 2'b10;
   localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

   typedef enum logic {
      INIT_WAIT = 1'b0,
      RUN       = 1'b1
   } state_t;

   // A single-beat burst is both first and last, hence SOM_EOM.
   function automatic logic [1:0] frame_code(input logic first, input logic last);
      if (first && last) return CNTL_SOM_EOM;
      if (first)         return CNTL_SOM;
      if (last)          return CNTL_EOM;
      return CNTL_MOM;
   endfunction

endpackage

// File: rtl/dfi_tdm_bridge_if.sv
// PHY-side bus of the bridge: registered command slot out, read beats in.
interface dfi_tdm_bridge_if #(
   parameter int NUM_CHAN  = 2,
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 4,
   parameter int BANK_W    = 2,
   parameter int ADDR_W    = 12
);
   localparam int CH_W = $clog2(NUM_CHAN);

   // dfi__phy__cs and phy__dfi__valid are single-cycle strobes with no
   // backpressure: a transfer happens on every clock on which they are high.
   logic                        dfi__phy__cs;
   logic                        dfi__phy__cmd1;
   logic                        dfi__phy__cmd0;
   logic [BANK_W-1:0]           dfi__phy__bank;
   logic [ADDR_W-1:0]           dfi__phy__addr;
   logic [NUM_WORDS*WORD_W-1:0] dfi__phy__data;
   logic [CH_W-1:0]             dfi__phy__chan;
   logic                        phy__dfi__valid;
   logic [NUM_WORDS*WORD_W-1:0] phy__dfi__data;

   modport master (
      output dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0, dfi__phy__bank,
             dfi__phy__addr, dfi__phy__data, dfi__phy__chan,
      input  phy__dfi__valid, phy__dfi__data
   );

   modport slave (
      input  dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0, dfi__phy__bank,
             dfi__phy__addr, dfi__phy__data, dfi__phy__chan,
      output phy__dfi__valid, phy__dfi__data
   );

endinterface

// File: rtl/dfi_tag_fifo.sv
// Small FIFO of channel tags for outstanding reads; push when full and pop
// when empty are ignored.
module dfi_tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == DEPTH_L);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/dfi_tdm_bridge.sv
// Shares one DFI PHY between NUM_CHAN memory controllers by round-robin time
// slots, and routes read bursts back to their owners via a tag FIFO.
module dfi_tdm_bridge
   import dfi_tdm_pkg::*;
#(
   parameter int NUM_CHAN    = 2,
   parameter int WORD_W      = 32,
   parameter int NUM_WORDS   = 4,
   parameter int BANK_W      = 2,
   parameter int ADDR_W      = 12,
   parameter int BURST_SIZE  = 2,
   parameter int TAG_DEPTH   = 4,
   parameter int INIT_CYCLES = 16
) (
   input  logic                              clk,
   input  logic                              reset_poweron,
   input  logic [NUM_CHAN-1:0]               mmc__dfi__cs,
   input  logic [NUM_CHAN-1:0]               mmc__dfi__cmd1,
   input  logic [NUM_CHAN-1:0]               mmc__dfi__cmd0,
   input  logic [NUM_CHAN*BANK_W-1:0]        mmc__dfi__bank,
   input  logic [NUM_CHAN*ADDR_W-1:0]        mmc__dfi__addr,
   input  logic [NUM_CHAN*NUM_WORDS*WORD_W-1:0] mmc__dfi__data,
   output logic                              dfi__mmc__init_done,
   output logic [NUM_CHAN-1:0]               dfi__mmc__valid,
   output logic [NUM_CHAN*2-1:0]             dfi__mmc__cntl,
   output logic [NUM_CHAN*NUM_WORDS*WORD_W-1:0] dfi__mmc__data,
   output logic [NUM_CHAN-1:0]               dfi__mmc__ovfl,
   output logic                              dfi__mmc__rd_err,
   output state_t                            fsm_state,
   dfi_tdm_bridge_if.master                  phy
);
   localparam int CH_W = $clog2(NUM_CHAN);
   localparam int DW   = NUM_WORDS * WORD_W;
   localparam int IC_W = $clog2(INIT_CYCLES + 1);
   localparam int BC_W = $clog2(BURST_SIZE) + 1;

   state_t            state_q, state_d;
   logic [IC_W-1:0]   init_cnt_q;
   logic [CH_W-1:0]   slot_q;
   logic              run;

   logic [NUM_CHAN-1:0] pend_q;
   logic [1:0]          pcmd_q  [NUM_CHAN];
   logic [BANK_W-1:0]   pbank_q [NUM_CHAN];
   logic [ADDR_W-1:0]   paddr_q [NUM_CHAN];
   logic [DW-1:0]       pdata_q [NUM_CHAN];

   logic [1:0]        slot_cmd;
   logic              issue, issue_read;
   logic              tag_full, tag_empty, rd_hit, rd_last;
   logic [CH_W-1:0]   tag_head;
   logic [BC_W-1:0]   beat_q;

   assign run                 = (state_q == RUN);
   assign dfi__mmc__init_done = run;
   assign fsm_state           = state_q;

   always_comb begin
      state_d = state_q;
      if (state_q == INIT_WAIT && init_cnt_q == IC_W'(INIT_CYCLES - 1)) state_d = RUN;
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         state_q    <= INIT_WAIT;
         init_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT_WAIT) init_cnt_q <= init_cnt_q + IC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron)                               slot_q <= '0;
      else if (!run || slot_q == CH_W'(NUM_CHAN - 1))  slot_q <= '0;
      else                                             slot_q <= slot_q + CH_W'(1);
   end

   // A READ waits in its slot while every tag is in use.
   always_comb begin
      slot_cmd   = pcmd_q[slot_q];
      issue      = run && pend_q[slot_q] && !((slot_cmd == CMD_READ) && tag_full);
      issue_read = issue && (slot_cmd == CMD_READ);
      rd_hit     = phy.phy__dfi__valid && !tag_empty;
      rd_last    = (beat_q == BC_W'(BURST_SIZE - 1));
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         pend_q         <= '0;
         dfi__mmc__ovfl <= '0;
         for (int ch = 0; ch < NUM_CHAN; ch++) begin
            pcmd_q[ch]  <= '0;
            pbank_q[ch] <= '0;
            paddr_q[ch] <= '0;
            pdata_q[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CHAN; ch++) begin
            if (issue && slot_q == CH_W'(ch)) pend_q[ch] <= 1'b0;
            // An issuing slot frees up in time to take a same-cycle command.
            if (run && mmc__dfi__cs[ch]) begin
               if (!pend_q[ch] || (issue && slot_q == CH_W'(ch))) begin
                  pend_q[ch]  <= 1'b1;
                  pcmd_q[ch]  <= {mmc__dfi__cmd1[ch], mmc__dfi__cmd0[ch]};
                  pbank_q[ch] <= mmc__dfi__bank[ch*BANK_W +: BANK_W];
                  paddr_q[ch] <= mmc__dfi__addr[ch*ADDR_W +: ADDR_W];
                  pdata_q[ch] <= mmc__dfi__data[ch*DW +: DW];
               end else begin
                  dfi__mmc__ovfl[ch] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         phy.dfi__phy__cs   <= 1'b0;
         phy.dfi__phy__cmd1 <= 1'b0;
         phy.dfi__phy__cmd0 <= 1'b0;
         phy.dfi__phy__bank <= '0;
         phy.dfi__phy__addr <= '0;
         phy.dfi__phy__data <= '0;
         phy.dfi__phy__chan <= '0;
      end else begin
         phy.dfi__phy__cs                         <= issue;
         phy.dfi__phy__chan                       <= slot_q;
         {phy.dfi__phy__cmd1, phy.dfi__phy__cmd0} <= issue ? slot_cmd : CMD_NOP;
         if (issue) begin
            phy.dfi__phy__bank <= pbank_q[slot_q];
            phy.dfi__phy__addr <= paddr_q[slot_q];
            phy.dfi__phy__data <= pdata_q[slot_q];
         end
      end
   end

   dfi_tag_fifo #(
      .WIDTH (CH_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (reset_poweron),
      .push      (issue_read),
      .push_data (slot_q),
      .pop       (rd_hit && rd_last),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         dfi__mmc__valid  <= '0;
         dfi__mmc__cntl   <= '0;
         dfi__mmc__data   <= '0;
         dfi__mmc__rd_err <= 1'b0;
         beat_q           <= '0;
      end else begin
         if (phy.phy__dfi__valid && tag_empty) dfi__mmc__rd_err <= 1'b1;
         if (rd_hit) beat_q <= rd_last ? '0 : beat_q + BC_W'(1);
         for (int ch = 0; ch < NUM_CHAN; ch++) begin
            dfi__mmc__valid[ch] <= rd_hit && (tag_head == CH_W'(ch));
            if (rd_hit && tag_head == CH_W'(ch)) begin
               dfi__mmc__data[ch*DW +: DW] <= phy.phy__dfi__data;
               dfi__mmc__cntl[ch*2 +: 2]   <= frame_code(beat_q == '0, rd_last);
            end
         end
      end
   end

endmodule

// File: tb/tb_dfi_tdm_bridge.sv
// Directed scoreboard bench for dfi_tdm_bridge with default parameters.
module tb_dfi_tdm_bridge;
   import dfi_tdm_pkg::*;

   localparam int NUM_CHAN  = 2;
   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 4;
   localparam int BANK_W    = 2;
   localparam int ADDR_W    = 12;
   localparam int CH_W      = 1;
   localparam int DW        = NUM_WORDS * WORD_W;
   localparam int PW        = CH_W + 2 + BANK_W + ADDR_W + DW;
   localparam int RW        = CH_W + 2 + DW;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_CHAN-1:0]        cs, cmd1, cmd0;
   logic [NUM_CHAN*BANK_W-1:0] bank;
   logic [NUM_CHAN*ADDR_W-1:0] addr;
   logic [NUM_CHAN*DW-1:0]     wdata;
   logic                       init_done, rd_err;
   logic [NUM_CHAN-1:0]        mmc_valid, ovfl;
   logic [NUM_CHAN*2-1:0]      mmc_cntl;
   logic [NUM_CHAN*DW-1:0]     mmc_data;
   state_t                     fsm_state;

   dfi_tdm_bridge_if #(.NUM_CHAN(NUM_CHAN), .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS),
                       .BANK_W(BANK_W), .ADDR_W(ADDR_W)) phy_if ();

   dfi_tdm_bridge dut (
      .clk                 (clk),
      .reset_poweron       (rst),
      .mmc__dfi__cs        (cs),
      .mmc__dfi__cmd1      (cmd1),
      .mmc__dfi__cmd0      (cmd0),
      .mmc__dfi__bank      (bank),
      .mmc__dfi__addr      (addr),
      .mmc__dfi__data      (wdata),
      .dfi__mmc__init_done (init_done),
      .dfi__mmc__valid     (mmc_valid),
      .dfi__mmc__cntl      (mmc_cntl),
      .dfi__mmc__data      (mmc_data),
      .dfi__mmc__ovfl      (ovfl),
      .dfi__mmc__rd_err    (rd_err),
      .fsm_state           (fsm_state),
      .phy                 (phy_if)
   );

   always #5 clk = ~clk;

   int edge_n;
   always @(posedge clk or posedge rst) begin
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   int total = 0;
   int bad   = 0;
   bit done  = 0;
   logic [PW-1:0] phy_exp_q[$];
   logic [RW-1:0] rd_exp_q[$];

   function automatic logic [DW-1:0] mk_data(input int n);
      return {32'h4000_0000 | 32'(n), 32'h3000_0000 | 32'(n),
              32'h2000_0000 | 32'(n), 32'h1000_0000 | 32'(n)};
   endfunction

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic wait_clk();
      @(posedge clk);
      #1;
   endtask

   // Slot s issues on the edge after a command is loaded at an edge n with (n-16)%2 == s.
   task automatic align_odd();
      while (edge_n % 2 != 1) wait_clk();
   endtask

   task automatic set_cmd(input int ch, input logic [1:0] c, input logic [1:0] b,
                          input logic [11:0] a, input int dn, input bit exp_issue);
      cs[ch]   = 1'b1;
      cmd1[ch] = c[1];
      cmd0[ch] = c[0];
      bank[ch*BANK_W +: BANK_W] = b;
      addr[ch*ADDR_W +: ADDR_W] = a;
      wdata[ch*DW +: DW]        = mk_data(dn);
      if (exp_issue) phy_exp_q.push_back({CH_W'(ch), c, b, a, mk_data(dn)});
   endtask

   task automatic strobe();
      wait_clk();
      cs = '0;
   endtask

   task automatic beat(input int ch, input logic [1:0] cntl, input int dn, input bit exp_route);
      if (exp_route) rd_exp_q.push_back({CH_W'(ch), cntl, mk_data(dn)});
      phy_if.phy__dfi__valid = 1'b1;
      phy_if.phy__dfi__data  = mk_data(dn);
      wait_clk();
      phy_if.phy__dfi__valid = 1'b0;
   endtask

   task automatic reset_checks();
      chk("rst_init_done", 256'(init_done), 256'(0));
      chk("rst_state", 256'(fsm_state), 256'(INIT_WAIT));
      chk("rst_phy_cs_cmd", 256'({phy_if.dfi__phy__cs, phy_if.dfi__phy__cmd1, phy_if.dfi__phy__cmd0}), 256'(0));
      chk("rst_phy_chan_bank_addr", 256'({phy_if.dfi__phy__chan, phy_if.dfi__phy__bank, phy_if.dfi__phy__addr}), 256'(0));
      chk("rst_phy_data", 256'(phy_if.dfi__phy__data), 256'(0));
      chk("rst_mmc_valid", 256'(mmc_valid), 256'(0));
      chk("rst_mmc_cntl", 256'(mmc_cntl), 256'(0));
      chk("rst_mmc_data", 256'(mmc_data), 256'(0));
      chk("rst_ovfl_rd_err", 256'({ovfl, rd_err}), 256'(0));
   endtask

   task automatic monitor();
      logic [PW-1:0] pgot;
      logic [RW-1:0] rgot;
      int cyc = 0;
      while (!done) begin
         @(negedge clk);
         cyc++;
         if (cyc > 20000) begin
            $display("FAIL watchdog cycles=%0d limit=20000", cyc);
            $fatal(1, "watchdog expired");
         end
         if (!rst && phy_if.dfi__phy__cs) begin
            pgot = {phy_if.dfi__phy__chan, phy_if.dfi__phy__cmd1, phy_if.dfi__phy__cmd0,
                    phy_if.dfi__phy__bank, phy_if.dfi__phy__addr, phy_if.dfi__phy__data};
            if (phy_exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL phy_cmd unexpected got=%0h exp=none", pgot);
            end else begin
               chk("phy_cmd", 256'(pgot), 256'(phy_exp_q.pop_front()));
            end
         end
         for (int ch = 0; ch < NUM_CHAN; ch++) begin
            if (!rst && mmc_valid[ch]) begin
               rgot = {CH_W'(ch), mmc_cntl[ch*2 +: 2], mmc_data[ch*DW +: DW]};
               if (rd_exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rd_beat unexpected got=%0h exp=none", rgot);
               end else begin
                  chk("rd_beat", 256'(rgot), 256'(rd_exp_q.pop_front()));
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      cs = '0; cmd1 = '0; cmd0 = '0; bank = '0; addr = '0; wdata = '0;
      phy_if.phy__dfi__valid = 1'b0;
      phy_if.phy__dfi__data  = '0;
      fork
         monitor();
         begin
            int seen;
            // Reset values, then init timing with a cs pulse that must be ignored.
            repeat (3) @(posedge clk);
            #1;
            reset_checks();
            @(negedge clk);
            rst = 1'b0;
            repeat (4) wait_clk();
            set_cmd(0, CMD_WRITE, 2'd1, 12'h0F0, 1, 1'b0);
            strobe();
            while (edge_n < 15) wait_clk();
            chk("init_done_at_15", 256'(init_done), 256'(0));
            chk("state_at_15", 256'(fsm_state), 256'(INIT_WAIT));
            chk("phy_chan_in_init", 256'(phy_if.dfi__phy__chan), 256'(0));
            wait_clk();
            chk("init_done_at_16", 256'(init_done), 256'(1));
            chk("state_at_16", 256'(fsm_state), 256'(RUN));

            // Beat with no outstanding read.
            beat(0, CNTL_MOM, 2, 1'b0);
            chk("rd_err_untagged", 256'(rd_err), 256'(1));
            chk("no_valid_untagged", 256'(mmc_valid), 256'(0));

            // Both channels write together: chan 0 then chan 1 on consecutive cycles.
            align_odd();
            set_cmd(0, CMD_WRITE, 2'd1, 12'h123, 3, 1'b1);
            set_cmd(1, CMD_WRITE, 2'd2, 12'h456, 4, 1'b1);
            strobe();
            wait_clk();
            chk("dual_wr_first", 256'({phy_if.dfi__phy__cs, phy_if.dfi__phy__chan}), 256'(2'b10));
            wait_clk();
            chk("dual_wr_second", 256'({phy_if.dfi__phy__cs, phy_if.dfi__phy__chan}), 256'(2'b11));

            // Second ch1 command while the first still waits for its slot.
            align_odd();
            set_cmd(1, CMD_WRITE, 2'd3, 12'h777, 5, 1'b1);
            strobe();
            set_cmd(1, CMD_WRITE, 2'd0, 12'h888, 6, 1'b0);
            strobe();
            chk("ovfl_ch1", 256'(ovfl), 256'(2'b10));
            repeat (3) wait_clk();

            // ch0 re-loads in the very cycle its slot issues.
            align_odd();
            set_cmd(0, CMD_REFRESH, 2'd0, 12'h0AA, 7, 1'b1);
            strobe();
            set_cmd(0, CMD_WRITE, 2'd1, 12'h0BB, 8, 1'b1);
            strobe();
            chk("no_ovfl_on_issue", 256'(ovfl), 256'(2'b10));
            repeat (4) wait_clk();

            // Reads on both channels, four beats back.
            align_odd();
            set_cmd(0, CMD_READ, 2'd2, 12'h100, 9, 1'b1);
            set_cmd(1, CMD_READ, 2'd3, 12'h200, 10, 1'b1);
            strobe();
            repeat (3) wait_clk();
            beat(0, CNTL_SOM, 11, 1'b1);
            beat(0, CNTL_EOM, 12, 1'b1);
            beat(1, CNTL_SOM, 13, 1'b1);
            beat(1, CNTL_EOM, 14, 1'b1);
            repeat (2) wait_clk();
            chk("bursts_routed", 256'(rd_exp_q.size()), 256'(0));

            // Fill all four tags, then a fifth read must wait for a burst to finish.
            align_odd();
            set_cmd(0, CMD_READ, 2'd0, 12'h301, 20, 1'b1);
            set_cmd(1, CMD_READ, 2'd1, 12'h302, 21, 1'b1);
            strobe();
            wait_clk();
            align_odd();
            set_cmd(0, CMD_READ, 2'd2, 12'h303, 22, 1'b1);
            set_cmd(1, CMD_READ, 2'd3, 12'h304, 23, 1'b1);
            strobe();
            repeat (3) wait_clk();
            align_odd();
            set_cmd(0, CMD_READ, 2'd1, 12'h305, 24, 1'b1);
            strobe();
            seen = 0;
            repeat (6) begin
               wait_clk();
               if (phy_if.dfi__phy__cs) seen++;
            end
            chk("fifth_read_held", 256'(seen), 256'(0));
            beat(0, CNTL_SOM, 25, 1'b1);
            beat(0, CNTL_EOM, 26, 1'b1);
            for (int i = 0; i < 8 && phy_exp_q.size() != 0; i++) wait_clk();
            chk("fifth_read_issued", 256'(phy_exp_q.size()), 256'(0));

            // Reset in the middle of a burst with tags outstanding.
            beat(1, CNTL_SOM, 27, 1'b1);
            wait_clk();
            rst = 1'b1;
            #1;
            reset_checks();
            @(negedge clk);
            rst = 1'b0;
            while (edge_n < 16) wait_clk();
            chk("init_done_after_rst", 256'(init_done), 256'(1));
            beat(0, CNTL_MOM, 28, 1'b0);
            chk("rd_err_tags_flushed", 256'(rd_err), 256'(1));
            chk("no_valid_after_flush", 256'(mmc_valid), 256'(0));
            repeat (3) wait_clk();
            chk("phy_queue_drained", 256'(phy_exp_q.size()), 256'(0));
            chk("rd_queue_drained", 256'(rd_exp_q.size()), 256'(0));
            done = 1'b1;
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dfi_tdm_bridge.md
DFI_TDM_BRIDGE -- requirements
Module: dfi_tdm_bridge

Interface
REQ-001 Parameters SHALL be the following, one per line as name, default, meaning:
- NUM_CHAN, 2, MMC channels sharing one PHY (2..8).
- WORD_W, 32, lane word width.
- NUM_WORDS, 4, words per beat.
- BANK_W, 2, bank address width.
- ADDR_W, 12, PHY address width.
- BURST_SIZE, 2, read beats per read command (1..8).
- TAG_DEPTH, 4, outstanding-read tag FIFO depth (power of 2).
- INIT_CYCLES, 16, cycles from reset release to init_done.

REQ-002 Ports SHALL be the following, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock.
- reset_poweron, in, 1, asynchronous active-high reset.
- mmc__dfi__cs, in, NUM_CHAN, per-channel command strobe.
- mmc__dfi__cmd1 and mmc__dfi__cmd0, in, NUM_CHAN each, command code.
- mmc__dfi__bank, in, NUM_CHAN*BANK_W, command bank.
- mmc__dfi__addr, in, NUM_CHAN*ADDR_W, command address.
- mmc__dfi__data, in, NUM_CHAN*NUM_WORDS*WORD_W, write data.
- dfi__mmc__init_done, out, 1, initialisation complete.
- dfi__mmc__valid, out, NUM_CHAN, read beat valid.
- dfi__mmc__cntl, out, NUM_CHAN*2, SOM/MOM/EOM framing.
- dfi__mmc__data, out, NUM_CHAN*NUM_WORDS*WORD_W, read data.
- dfi__mmc__ovfl, out, NUM_CHAN, sticky dropped-command flag.
- dfi__mmc__rd_err, out, 1, sticky untagged-beat flag.
- dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0, out, 1 each, PHY command.
- dfi__phy__bank, out, BANK_W, PHY bank.
- dfi__phy__addr, out, ADDR_W, PHY address.
- dfi__phy__data, out, NUM_WORDS*WORD_W, PHY write data.
- dfi__phy__chan, out, clog2(NUM_CHAN), channel owning the current PHY slot.
- phy__dfi__valid, in, 1, PHY read beat valid.
- phy__dfi__data, in, NUM_WORDS*WORD_W, PHY read data.

Function
REQ-003 The init FSM SHALL have the states INIT_WAIT and RUN; it SHALL count INIT_CYCLES clocks in INIT_WAIT, then enter RUN and assert dfi__mmc__init_done, which stays high until reset.
REQ-004 Command encoding SHALL be {cmd1,cmd0}: 00 NOP, 01 READ, 10 WRITE, 11 REFRESH; cs=1 marks a valid command.
REQ-005 Each channel SHALL have one pending slot holding cmd, bank, addr and data; the slot is loaded when cs=1 in RUN, and cs is ignored in INIT_WAIT.
REQ-006 If a channel has cs=1 while its slot is pending and not issuing this cycle, the new command SHALL be dropped, the old one retained, and ovfl[ch] set sticky.
REQ-007 If a channel's slot issues and cs=1 arrives in the same cycle, the new command SHALL be loaded with no overflow.
REQ-008 Slot counter: in RUN it SHALL advance 0..NUM_CHAN-1 and wrap each clk; it SHALL be held at 0 in INIT_WAIT.
REQ-009 Issue: when channel s = slot is pending, its command SHALL drive the registered PHY outputs the next cycle with dfi__phy__cs=1 and dfi__phy__chan=s, and the slot is cleared; otherwise dfi__phy__cs=0 and dfi__phy__chan=s.
REQ-010 A READ SHALL issue only if the tag FIFO is not full; if full, it stays pending and that slot emits cs=0.
REQ-011 Each issued READ SHALL push s into the tag FIFO.
REQ-012 Return path: each phy__dfi__valid beat SHALL route to the FIFO-head channel, registered one cycle as valid[ch]=1 with data[ch]=beat.
REQ-013 A per-return beat counter SHALL drive cntl: beat 0 = SOM, beat BURST_SIZE-1 = EOM, otherwise MOM, and SOM_EOM when BURST_SIZE=1.
REQ-014 On the last beat of a burst, the tag FIFO SHALL pop and the beat counter SHALL reset to 0.
REQ-015 A beat arriving with the tag FIFO empty SHALL be dropped and set rd_err sticky; a push in the same cycle is not visible to that beat.
REQ-016 Non-target channels SHALL have valid=0; data and cntl hold their last value.

Reset
REQ-017 Asynchronous reset_poweron SHALL clear the FSM to INIT_WAIT and clear the init counter, slot counter, pending slots, tag FIFO, beat counter, ovfl, rd_err, init_done, all valids and dfi__phy__cs/cmd1/cmd0.
REQ-018 On reset, data, bank, addr, cntl and chan outputs SHALL be 0.
REQ-019 A reset mid-burst SHALL discard all in-flight tags and pending commands.

Structure
REQ-020 Package dfi_tdm_pkg SHALL hold the command encodings, the cntl codes (MOM=00, SOM=01, EOM=10, SOM_EOM=11) and the FSM state enum.
REQ-021 The tag FIFO SHALL be the sub-module dfi_tag_fifo, parametrised by width and depth, with full/empty outputs.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset release, INIT_CYCLES=16: init_done rises on cycle 16; cs pulses before that -> no PHY cs.
- NUM_CHAN=2, both channels WRITE in the same cycle -> PHY cs on two consecutive cycles, chan 0 then 1, with correct data.
- ch1 issues cs twice before its slot -> ovfl[1]=1 and only the first command appears.
- BURST_SIZE=2, READ on ch0 then ch1, 4 PHY beats -> ch0 SOM,EOM then ch1 SOM,EOM.
- TAG_DEPTH=4, 5 READs with no returns -> the fifth is held; one burst return frees it next slot.
- PHY valid with no outstanding read -> rd_err=1, no dfi__mmc__valid.
